// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 control unit.
package lc3_pkg;

    // Controller states; StHalt is the reset state.
    typedef enum logic [4:0] {
        StHalt, St18, St33, St35, St32,
        St01, St05, St09,
        St00, St22, St12, St04, St21,
        St06, St07, St25, St27, St23, St16,
        StP1, StP2
    } state_t;

    // Opcodes, IR[15:12]
    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;

    // PCMUX selects
    localparam logic [1:0] PcmuxInc   = 2'b00;
    localparam logic [1:0] PcmuxBus   = 2'b01;
    localparam logic [1:0] PcmuxAdder = 2'b10;

    // ADDR2MUX selects
    localparam logic [1:0] Addr2Zero  = 2'b00;
    localparam logic [1:0] Addr2Off6  = 2'b01;
    localparam logic [1:0] Addr2Off9  = 2'b10;
    localparam logic [1:0] Addr2Off11 = 2'b11;

    // ALU functions
    localparam logic [1:0] AlukAdd   = 2'b00;
    localparam logic [1:0] AlukAnd   = 2'b01;
    localparam logic [1:0] AlukNot   = 2'b10;
    localparam logic [1:0] AlukPassA = 2'b11;

endpackage

// File: rtl/lc3_control_unit.sv
// Moore sequencer for the LC-3 datapath: fetch, decode and execute of a
// reduced instruction set. Only LD_MDR during memory reads follows Mem_Ack.
module lc3_control_unit
    import lc3_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    input  logic       Mem_Ack,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_WE
);

    state_t state_q, state_d;

    // State register, asynchronously forced to HALT.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StHalt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; everything defaults low.
    always_comb begin
        state_d    = state_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PcmuxInc;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = Addr2Zero;
        ALUK       = AlukAdd;
        Mem_CE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state_q)
            StHalt: begin
                if (Run) state_d = St18;
            end
            St18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                PCMUX   = PcmuxInc;
                LD_PC   = 1'b1;
                state_d = St33;
            end
            St33, St25: begin
                Mem_CE = 1'b1;
                if (Mem_Ack) begin
                    LD_MDR  = 1'b1;
                    state_d = (state_q == St33) ? St35 : St27;
                end
            end
            St35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = St32;
            end
            St32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OpAdd:   state_d = St01;
                    OpAnd:   state_d = St05;
                    OpNot:   state_d = St09;
                    OpBr:    state_d = St00;
                    OpJmp:   state_d = St12;
                    OpJsr:   state_d = St04;
                    OpLdr:   state_d = St06;
                    OpStr:   state_d = St07;
                    OpPause: state_d = StP1;
                    default: state_d = St18;
                endcase
            end
            St01, St05, St09: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state_q == St01) ? AlukAdd :
                          (state_q == St05) ? AlukAnd : AlukNot;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = St18;
            end
            St00: begin
                state_d = BEN ? St22 : St18;
            end
            St22: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = Addr2Off9;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
                state_d  = St18;
            end
            St12: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                ADDR2MUX = Addr2Zero;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
                state_d  = St18;
            end
            St04: begin
                DRMUX   = 1'b1;
                GatePC  = 1'b1;
                LD_REG  = 1'b1;
                state_d = St21;
            end
            St21: begin
                ADDR1MUX = 1'b0;
                ADDR2MUX = Addr2Off11;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
                state_d  = St18;
            end
            St06, St07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = Addr2Off6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == St06) ? St25 : St23;
            end
            St27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = St18;
            end
            St23: begin
                SR1MUX  = 1'b0;
                ALUK    = AlukPassA;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = St16;
            end
            St16: begin
                Mem_CE = 1'b1;
                Mem_WE = 1'b1;
                if (Mem_Ack) state_d = St18;
            end
            StP1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = StP2;
            end
            StP2: begin
                if (!Continue) state_d = St18;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Directed bench for lc3_control_unit: each step pushes the expected output
// vector for that cycle; a monitor pops and compares mid low-phase.
module tb_lc3_control_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'b0000;
    logic       IR_5 = 1'b0;
    logic       BEN = 1'b0;
    logic       Mem_Ack = 1'b0;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_CE, Mem_WE;

    lc3_control_unit dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .BEN(BEN), .Mem_Ack(Mem_Ack),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_CE(Mem_CE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    logic [23:0] obs;
    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                  SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_CE, Mem_WE};

    // Single-field masks in the obs bit order.
    localparam logic [23:0] MLdMar  = 24'h1 << 23;
    localparam logic [23:0] MLdMdr  = 24'h1 << 22;
    localparam logic [23:0] MLdIr   = 24'h1 << 21;
    localparam logic [23:0] MLdBen  = 24'h1 << 20;
    localparam logic [23:0] MLdCc   = 24'h1 << 19;
    localparam logic [23:0] MLdReg  = 24'h1 << 18;
    localparam logic [23:0] MLdPc   = 24'h1 << 17;
    localparam logic [23:0] MLdLed  = 24'h1 << 16;
    localparam logic [23:0] MGPc    = 24'h1 << 15;
    localparam logic [23:0] MGMdr   = 24'h1 << 14;
    localparam logic [23:0] MGAlu   = 24'h1 << 13;
    localparam logic [23:0] MGMar   = 24'h1 << 12;
    localparam logic [23:0] MPcAdd  = 24'h2 << 10;
    localparam logic [23:0] MDr     = 24'h1 << 9;
    localparam logic [23:0] MSr1    = 24'h1 << 8;
    localparam logic [23:0] MSr2    = 24'h1 << 7;
    localparam logic [23:0] MA1     = 24'h1 << 6;
    localparam logic [23:0] MA2Off6 = 24'h1 << 4;
    localparam logic [23:0] MA2Off9 = 24'h2 << 4;
    localparam logic [23:0] MA2Off11 = 24'h3 << 4;
    localparam logic [23:0] MAluAnd = 24'h1 << 2;
    localparam logic [23:0] MAluNot = 24'h2 << 2;
    localparam logic [23:0] MAluPa  = 24'h3 << 2;
    localparam logic [23:0] MCe     = 24'h1 << 1;
    localparam logic [23:0] MWe     = 24'h1;

    // Expected vectors per state.
    localparam logic [23:0] XZero = 24'h0;
    localparam logic [23:0] X18   = MGPc | MLdMar | MLdPc;
    localparam logic [23:0] XRdW  = MCe;
    localparam logic [23:0] XRdA  = MCe | MLdMdr;
    localparam logic [23:0] X35   = MGMdr | MLdIr;
    localparam logic [23:0] X32   = MLdBen;
    localparam logic [23:0] XAlu  = MSr1 | MGAlu | MLdReg | MLdCc;
    localparam logic [23:0] X22   = MA2Off9 | MPcAdd | MLdPc;
    localparam logic [23:0] X12   = MSr1 | MA1 | MPcAdd | MLdPc;
    localparam logic [23:0] X04   = MDr | MGPc | MLdReg;
    localparam logic [23:0] X21   = MA2Off11 | MPcAdd | MLdPc;
    localparam logic [23:0] XAddr = MSr1 | MA1 | MA2Off6 | MGMar | MLdMar;
    localparam logic [23:0] X27   = MGMdr | MLdReg | MLdCc;
    localparam logic [23:0] X23   = MAluPa | MGAlu | MLdMdr;
    localparam logic [23:0] X16   = MCe | MWe;
    localparam logic [23:0] XP1   = MLdLed;

    logic [23:0] exp_q[$];
    string       tag_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    // Scoreboard monitor: compare each queued expectation mid low-phase.
    always begin
        logic [23:0] e;
        string       t;
        @(negedge Clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_total++;
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    end

    // Drive current inputs (already set) and queue this cycle's expectation.
    task automatic push(input logic [23:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic step(input logic [23:0] e, input string t);
        push(e, t);
        @(negedge Clk);
    endtask

    // Zero-wait fetch/decode: S18, S33, S35, S32.
    task automatic fetch(input string t);
        Mem_Ack = 1'b1;
        step(X18, {t, "_s18"});
        step(XRdA, {t, "_s33"});
        step(X35, {t, "_s35"});
        step(X32, {t, "_s32"});
    endtask

    initial begin
        #1;
        n_total++;
        assert (obs === XZero) n_pass++;
        else $error("FAIL reset_outputs: observed %h expected %h", obs, XZero);
        @(negedge Clk);
        Reset = 1'b1;

        // Stays in HALT without Run, then start and reset mid-S33.
        step(XZero, "halt_idle0");
        step(XZero, "halt_idle1");
        Run = 1'b1;
        step(XZero, "halt_run");
        Run = 1'b0;
        Mem_Ack = 1'b0;
        step(X18, "rst_s18");
        push(XRdW, "rst_s33_wait");
        #3;
        Reset = 1'b0;
        #1;
        n_total++;
        assert (obs === XZero) n_pass++;
        else $error("FAIL reset_mid_s33: observed %h expected %h", obs, XZero);
        @(negedge Clk);
        Reset = 1'b1;
        step(XZero, "post_rst_halt0");
        step(XZero, "post_rst_halt1");

        // ADD immediate
        Run = 1'b1;
        Opcode = 4'b0001;
        IR_5 = 1'b1;
        step(XZero, "add_run");
        Run = 1'b0;
        fetch("add");
        step(XAlu | MSr2, "add_s01");
        // AND register
        Opcode = 4'b0101;
        IR_5 = 1'b0;
        fetch("and");
        step(XAlu | MAluAnd, "and_s05");
        // NOT
        Opcode = 4'b1001;
        IR_5 = 1'b1;
        fetch("not");
        step(XAlu | MSr2 | MAluNot, "not_s09");
        // BR taken then not taken
        Opcode = 4'b0000;
        BEN = 1'b1;
        fetch("brt");
        step(XZero, "brt_s00");
        step(X22, "brt_s22");
        BEN = 1'b0;
        fetch("brn");
        step(XZero, "brn_s00");
        // JMP
        Opcode = 4'b1100;
        fetch("jmp");
        step(X12, "jmp_s12");
        // JSR
        Opcode = 4'b0100;
        fetch("jsr");
        step(X04, "jsr_s04");
        step(X21, "jsr_s21");
        // STR with three wait cycles
        Opcode = 4'b0111;
        fetch("str");
        Mem_Ack = 1'b0;
        step(XAddr, "str_s07");
        step(X23, "str_s23");
        for (int i = 0; i < 3; i++) step(X16, "str_s16_wait");
        Mem_Ack = 1'b1;
        step(X16, "str_s16_ack");
        // LDR with two wait cycles
        Opcode = 4'b0110;
        fetch("ldr");
        Mem_Ack = 1'b0;
        step(XAddr, "ldr_s06");
        step(XRdW, "ldr_s25_w0");
        step(XRdW, "ldr_s25_w1");
        Mem_Ack = 1'b1;
        step(XRdA, "ldr_s25_ack");
        step(X27, "ldr_s27");
        // PAUSE: wait in P1, then hold in P2 until release
        Opcode = 4'b1101;
        fetch("pse");
        step(XP1, "pse_p1_wait");
        Continue = 1'b1;
        step(XP1, "pse_p1");
        for (int i = 0; i < 3; i++) step(XZero, "pse_p2_held");
        Continue = 1'b0;
        step(XZero, "pse_p2_rel");
        // Undefined opcode is a NOP
        Opcode = 4'b1111;
        fetch("nop");
        Run = 1'b1;
        step(X18, "nop_s18");
        Run = 1'b0;
        Mem_Ack = 1'b0;
        step(XRdW, "final_s33");

        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lc3_control_unit.md
# lc3_control_unit

Moore state machine that sequences the LC-3 datapath: instruction fetch, decode, and execute for a reduced instruction set. It drives every register load enable (including `LD_BEN` and `LD_CC` for the branch-enable/NZP unit), bus gates, mux selects, ALU function and memory handshake. It sits between the top-level run controls and the datapath, and consumes only `Opcode`, `IR_5`, `BEN` and `Mem_Ack` from it.

## Interface
- No parameters.
- `Clk`  in  1  clock.
- `Reset`  in  1  asynchronous, active-low.
- `Run`  in  1  start execution; sampled in HALT only.
- `Continue`  in  1  resume from PAUSE.
- `Opcode`  in  4  IR[15:12].
- `IR_5`  in  1  IR[5]; register/immediate select for ADD and AND.
- `BEN`  in  1  registered branch enable.
- `Mem_Ack`  in  1  memory access complete.
- `LD_MAR`, `LD_MDR`, `LD_IR`, `LD_BEN`, `LD_CC`, `LD_REG`, `LD_PC`, `LD_LED`  out  1 each  load enables.
- `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX`  out  1 each  bus drivers; at most one high per cycle.
- `PCMUX`  out  2  00 = PC+1, 01 = bus, 10 = address adder.
- `DRMUX`  out  1  0 = IR[11:9], 1 = R7.
- `SR1MUX`  out  1  0 = IR[11:9], 1 = IR[8:6].
- `SR2MUX`  out  1  0 = register, 1 = sext imm5.
- `ADDR1MUX`  out  1  0 = PC, 1 = SR1.
- `ADDR2MUX`  out  2  00 = 0, 01 = off6, 10 = off9, 11 = off11.
- `ALUK`  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA.
- `Mem_CE`, `Mem_WE`  out  1 each  memory enable and write; active-high.

## Operation
- Every output defaults to 0 in every state. Only the signals listed for a state are asserted.
- **HALT**: `Run=1` → S18.
- **S18**: `GatePC`, `LD_MAR`, `PCMUX=00`, `LD_PC` → S33.
- **S33**: `Mem_CE`. When `Mem_Ack=1`, also `LD_MDR` → S35; otherwise stay.
- **S35**: `GateMDR`, `LD_IR` → S32.
- **S32**: `LD_BEN`. Dispatch on `Opcode`:
  - 0001 → S01, 0101 → S05, 1001 → S09.
  - 0000 → S00, 1100 → S12, 0100 → S04.
  - 0110 → S06, 0111 → S07, 1101 → P1.
  - Any other opcode → S18 (NOP).
- **S01 / S05 / S09**: `SR1MUX=1`, `SR2MUX=IR_5`, `ALUK` = 00 / 01 / 10 respectively, `GateALU`, `LD_REG`, `LD_CC` → S18.
- **S00**: `BEN=1` → S22; otherwise → S18.
- **S22**: `ADDR1MUX=0`, `ADDR2MUX=10`, `PCMUX=10`, `LD_PC` → S18.
- **S12**: `SR1MUX=1`, `ADDR1MUX=1`, `ADDR2MUX=00`, `PCMUX=10`, `LD_PC` → S18.
- **S04**: `DRMUX=1`, `GatePC`, `LD_REG` → S21.
- **S21**: `ADDR1MUX=0`, `ADDR2MUX=11`, `PCMUX=10`, `LD_PC` → S18.
- **S06 / S07**: `SR1MUX=1`, `ADDR1MUX=1`, `ADDR2MUX=01`, `GateMARMUX`, `LD_MAR` → S25 (from S06) or S23 (from S07).
- **S25**: same as S33, but → S27 on ack.
- **S27**: `GateMDR`, `LD_REG`, `LD_CC` → S18.
- **S23**: `SR1MUX=0`, `ALUK=11`, `GateALU`, `LD_MDR` → S16.
- **S16**: `Mem_CE`, `Mem_WE`, held until `Mem_Ack=1` → S18.
- **P1**: `LD_LED`. `Continue=1` → P2.
- **P2**: `Continue=0` → S18.
- Run is ignored outside HALT. Once started, the machine only returns to HALT via `Reset`.

## Timing
- State register is asynchronously reset to HALT. All outputs are 0 during and after reset.
- `Reset` asserted mid-access drops `Mem_CE`/`Mem_WE` immediately. The pending memory operation is abandoned.
- All outputs are decoded from state, except `LD_MDR` in S33/S25, which is combinational on `Mem_Ack`.
- `Mem_Ack` is sampled at the rising edge. An ack already high in the first S33 cycle gives a 1-cycle access.
- Latency with zero-wait memory:
  - ALU ops and JMP: 5 cycles.
  - BR not taken: 5 cycles; BR taken: 6 cycles.
  - JSR: 6 cycles.
  - LDR and STR: 7 cycles.
  - Each extra wait cycle adds 1.
- `LD_BEN` in S32 captures BEN at the end of S32, so S00 evaluates the freshly loaded value.
- NZP written by `LD_CC` in instruction N is visible to a BR in instruction N+1.
- `Continue` held high at entry to P1 passes P1 in 1 cycle and then waits in P2 for release. One instruction per press.

## Structure
- Package `lc3_pkg` holds:
  - the `state_t` enum;
  - the opcode localparams;
  - the PCMUX, ADDR2MUX and ALUK encodings.
- Single module: one `always_ff` for state, one `always_comb` for next-state and outputs with all outputs defaulted at the top.
- No sub-module.

## Test plan
- Reset low mid-S33 with `Mem_CE=1` → all outputs 0 at once. State is HALT after release, and stays HALT until `Run=1`.
- `Run` pulse, `Opcode=0001`, `IR_5=1`, `Mem_Ack` always 1 → visits S18, S33, S35, S32, S01. In S01: `SR2MUX=1`, `ALUK=00`, `LD_CC=1`. Back in S18 on cycle 6.
- `Opcode=0000` with `BEN=1`, then `BEN=0` → S00→S22 with `PCMUX=10`, `ADDR2MUX=10`, `LD_PC=1`. Second case goes S00→S18 with no `LD_PC`.
- `Opcode=0111`, `Mem_Ack` low for 3 cycles in S16 → `Mem_CE=Mem_WE=1` for 4 cycles, then S18.
- `Opcode=0110`, `Mem_Ack` delayed 2 cycles → S25 lasts 3 cycles, `LD_MDR` only in the last. S27 asserts `LD_REG`+`LD_CC`.
- `Opcode=1101`, `Continue` held 1 for 5 cycles then 0 → `LD_LED` in P1, held in P2 for 4 cycles, then S18. `Opcode=1111` → S32 goes straight to S18.
